local_history_table_pipe: RTL and testbench

//  Parametrised per-branch local history table for the tournament predictor; successor to the fixed 8-cycle LHT.
//  - Lookup uses a valid/ready handshake with 1-cycle latency.
//  - A separate update port shifts the resolved outcome in independently of lookups.
//  - A reset/clear sweep FSM zeroes the array one entry per cycle, so there is no async reset on the array.

---
 rtl/local_history_table_pipe.sv | 103 ++++++++++
 tb/tb_local_history_table_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_history_table_pipe.sv
// Per-branch local history table with a valid/ready lookup port, an independent
// shift-in update port, and a one-entry-per-cycle zeroing sweep after reset or clear.
module local_history_table_pipe #(
  parameter int INDEX_BITS = 10,
  parameter int HIST_BITS  = 10,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [INDEX_BITS-1:0] lookup_pc,
  output logic                  result_valid,
  output logic [HIST_BITS-1:0]  result_history,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_pc,
  input  logic                  update_taken,
  output logic                  update_dropped,
  output logic                  init_busy
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [INDEX_BITS-1:0] sweep_ptr, sweep_ptr_nxt;
  logic [HIST_BITS-1:0]  lht [DEPTH];

  logic                  run;
  logic                  accept;
  logic                  upd_do;
  logic [HIST_BITS-1:0]  upd_hist;
  logic [HIST_BITS-1:0]  lookup_hist;

  assign run          = (state == ST_RUN);
  assign lookup_ready = run;
  assign init_busy    = !run;
  assign accept       = lookup_valid & lookup_ready;
  // Updates landing in the clear cycle would be wiped by the sweep anyway, so drop them.
  assign upd_do       = run & update_valid & ~clear;
  assign upd_hist     = {lht[update_pc][HIST_BITS-2:0], update_taken};

  always_comb begin
    lookup_hist = lht[lookup_pc];
    if (BYPASS != 0 && upd_do && (update_pc == lookup_pc))
      lookup_hist = upd_hist;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_nxt     = state;
    sweep_ptr_nxt = sweep_ptr;
    case (state)
      ST_INIT: begin
        sweep_ptr_nxt = sweep_ptr + 1'b1;
        if (sweep_ptr == '1)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clear) begin
          state_nxt     = ST_INIT;
          sweep_ptr_nxt = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_ptr_nxt;
    end
  end

  // NOTE: the array has no reset; the sweep zeroes it so it can map onto RAM.
  always_ff @(posedge clock) begin
    if (!run)
      lht[sweep_ptr] <= '0;
    else if (upd_do)
      lht[update_pc] <= upd_hist;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_valid   <= 1'b0;
      result_history <= '0;
      update_dropped <= 1'b0;
    end else begin
      result_valid   <= accept;
      if (accept)
        result_history <= lookup_hist;
      update_dropped <= update_valid & (!run | clear);
    end
  end

endmodule

// File: tb/tb_local_history_table_pipe.sv
// Directed bench for local_history_table_pipe: one instance with bypass, one without,
// driven by the same stimulus so both hold identical table contents.
module tb_local_history_table_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       lookup_valid;
  logic [9:0] lookup_pc;
  logic       update_valid;
  logic [9:0] update_pc;
  logic       update_taken;

  logic       ready1, rv1, drop1, busy1;
  logic [9:0] rh1;
  logic       ready0, rv0, drop0, busy0;
  logic [9:0] rh0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  local_history_table_pipe #(.INDEX_BITS(10), .HIST_BITS(10), .BYPASS(1)) dut_byp (
    .clock(clock), .reset(reset), .clear(clear),
    .lookup_valid(lookup_valid), .lookup_ready(ready1), .lookup_pc(lookup_pc),
    .result_valid(rv1), .result_history(rh1),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_dropped(drop1), .init_busy(busy1)
  );

  local_history_table_pipe #(.INDEX_BITS(10), .HIST_BITS(10), .BYPASS(0)) dut_nobyp (
    .clock(clock), .reset(reset), .clear(clear),
    .lookup_valid(lookup_valid), .lookup_ready(ready0), .lookup_pc(lookup_pc),
    .result_valid(rv0), .result_history(rh0),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_dropped(drop0), .init_busy(busy0)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_lookup(input logic [9:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [9:0] pc, input logic taken);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    n_cmp++;
    if ({ready1, rv1, rh1, drop1, busy1} !== {1'b0, 1'b0, 10'h000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got ready=%b rv=%b rh=%h drop=%b busy=%b want 0 0 000 0 1",
               ready1, rv1, rh1, drop1, busy1);
    end
    reset = 1'b1;
    wait_ready(n);
    n_cmp++;
    if (n !== 1024) begin
      n_err++;
      $display("FAIL init_length: got %0d cycles want 1024", n);
    end
    n_cmp++;
    if ({busy1, busy0, ready0} !== 3'b001) begin
      n_err++;
      $display("FAIL init_busy_fall: got busy1=%b busy0=%b ready0=%b want 0 0 1", busy1, busy0, ready0);
    end
    do_lookup(10'h3FF);
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h000}) begin
      n_err++;
      $display("FAIL lookup_3ff: got rv=%b rh=%h want 1 000", rv1, rh1);
    end
  endtask

  task automatic test_update_shift();
    do_update(10'h005, 1'b1);
    do_update(10'h005, 1'b1);
    do_update(10'h005, 1'b0);
    do_lookup(10'h005);
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h006}) begin
      n_err++;
      $display("FAIL pc005_TTN: got rv=%b rh=%h want 1 006", rv1, rh1);
    end
    tick();
    n_cmp++;
    if ({rv1, rh1} !== {1'b0, 10'h006}) begin
      n_err++;
      $display("FAIL result_hold: got rv=%b rh=%h want 0 006", rv1, rh1);
    end
    do_lookup(10'h004);
    n_cmp++;
    if (rh1 !== 10'h000) begin
      n_err++;
      $display("FAIL pc004_neighbour: got %h want 000", rh1);
    end
    do_lookup(10'h006);
    n_cmp++;
    if (rh1 !== 10'h000) begin
      n_err++;
      $display("FAIL pc006_neighbour: got %h want 000", rh1);
    end
  endtask

  task automatic test_saturation();
    update_valid = 1'b1;
    update_pc    = 10'h000;
    update_taken = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    update_valid = 1'b0;
    do_lookup(10'h000);
    n_cmp++;
    if (rh1 !== 10'h3FF) begin
      n_err++;
      $display("FAIL pc000_11T: got %h want 3ff", rh1);
    end
    do_update(10'h000, 1'b0);
    do_lookup(10'h000);
    n_cmp++;
    if (rh1 !== 10'h3FE) begin
      n_err++;
      $display("FAIL pc000_msb_shiftout: got %h want 3fe", rh1);
    end
  endtask

  task automatic test_bypass();
    do_update(10'h0A0, 1'b1);
    // Same-cycle lookup and update of 0x0A0; an unrelated update would differ in index.
    lookup_valid = 1'b1;
    lookup_pc    = 10'h0A0;
    update_valid = 1'b1;
    update_pc    = 10'h0A0;
    update_taken = 1'b1;
    tick();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h003}) begin
      n_err++;
      $display("FAIL bypass1_same_cycle: got rv=%b rh=%h want 1 003", rv1, rh1);
    end
    n_cmp++;
    if ({rv0, rh0} !== {1'b1, 10'h001}) begin
      n_err++;
      $display("FAIL bypass0_same_cycle: got rv=%b rh=%h want 1 001", rv0, rh0);
    end
    do_lookup(10'h0A0);
    n_cmp++;
    if ({rh1, rh0} !== {10'h003, 10'h003}) begin
      n_err++;
      $display("FAIL after_update: got byp=%h nobyp=%h want 003 003", rh1, rh0);
    end
    // Different indices in the same cycle stay independent.
    lookup_valid = 1'b1;
    lookup_pc    = 10'h005;
    update_valid = 1'b1;
    update_pc    = 10'h0A1;
    update_taken = 1'b1;
    tick();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    n_cmp++;
    if ({rh1, rh0} !== {10'h006, 10'h006}) begin
      n_err++;
      $display("FAIL diff_index: got byp=%h nobyp=%h want 006 006", rh1, rh0);
    end
  endtask

  task automatic test_back_to_back();
    lookup_valid = 1'b1;
    lookup_pc    = 10'h005;
    tick();
    lookup_pc = 10'h000;
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h006}) begin
      n_err++;
      $display("FAIL b2b_first: got rv=%b rh=%h want 1 006", rv1, rh1);
    end
    tick();
    lookup_pc = 10'h0A1;
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h3FE}) begin
      n_err++;
      $display("FAIL b2b_second: got rv=%b rh=%h want 1 3fe", rv1, rh1);
    end
    tick();
    lookup_valid = 1'b0;
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h001}) begin
      n_err++;
      $display("FAIL b2b_third: got rv=%b rh=%h want 1 001", rv1, rh1);
    end
  endtask

  task automatic test_clear();
    int n;
    clear        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 10'h005;
    update_valid = 1'b1;
    update_pc    = 10'h007;
    update_taken = 1'b1;
    tick();
    clear        = 1'b0;
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    n_cmp++;
    if ({rv1, rh1, drop1, busy1, ready1} !== {1'b1, 10'h006, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL clear_cycle: got rv=%b rh=%h drop=%b busy=%b ready=%b want 1 006 1 1 0",
               rv1, rh1, drop1, busy1, ready1);
    end
    wait_ready(n);
    n_cmp++;
    if (n !== 1024) begin
      n_err++;
      $display("FAIL clear_sweep_length: got %0d cycles want 1024", n);
    end
    do_lookup(10'h005);
    n_cmp++;
    if (rh1 !== 10'h000) begin
      n_err++;
      $display("FAIL pc005_cleared: got %h want 000", rh1);
    end
    do_lookup(10'h007);
    n_cmp++;
    if (rh1 !== 10'h000) begin
      n_err++;
      $display("FAIL dropped_update_absent: got %h want 000", rh1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_update(10'h0A0, 1'b1);
    do_update(10'h0A0, 1'b1);
    do_lookup(10'h0A0);
    n_cmp++;
    if (rh1 !== 10'h003) begin
      n_err++;
      $display("FAIL pre_reset_lookup: got %h want 003", rh1);
    end
    clear = 1'b1;
    tick();
    clear        = 1'b0;
    update_valid = 1'b1;
    update_pc    = 10'h0A0;
    update_taken = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    n_cmp++;
    if ({drop1, busy1} !== 2'b11) begin
      n_err++;
      $display("FAIL init_update_dropped: got drop=%b busy=%b want 1 1", drop1, busy1);
    end
    // Reset with a lookup pending: nothing may survive it.
    lookup_valid = 1'b1;
    lookup_pc    = 10'h0A0;
    reset        = 1'b0;
    #1;
    n_cmp++;
    if ({ready1, rv1, rh1, drop1, busy1} !== {1'b0, 1'b0, 10'h000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_sweep_reset: got ready=%b rv=%b rh=%h drop=%b busy=%b want 0 0 000 0 1",
               ready1, rv1, rh1, drop1, busy1);
    end
    tick();
    tick();
    lookup_valid = 1'b0;
    reset        = 1'b1;
    n = 0;
    while (!ready1 && n < 3000) begin
      clear = (n == 200);
      tick();
      n++;
      if (n == 10) begin
        n_cmp++;
        if (drop1 !== 1'b1) begin
          n_err++;
          $display("FAIL init_drop_after_reset: got %b want 1", drop1);
        end
      end
    end
    clear        = 1'b0;
    update_valid = 1'b0;
    n_cmp++;
    if (n !== 1024) begin
      n_err++;
      $display("FAIL reset_sweep_length: got %0d cycles want 1024", n);
    end
    do_lookup(10'h0A0);
    n_cmp++;
    if ({rv1, rh1} !== {1'b1, 10'h000}) begin
      n_err++;
      $display("FAIL pc0a0_after_reset: got rv=%b rh=%h want 1 000", rv1, rh1);
    end
  endtask

  initial begin
    reset        = 1'b0;
    clear        = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    update_valid = 1'b0;
    update_pc    = '0;
    update_taken = 1'b0;
    tick();
    tick();
    test_reset();
    test_update_shift();
    test_saturation();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
